// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 1024x768@60 raster timing constants shared by the video path
//    H_*/V_* : active, porch and sync lengths in clocks/lines
//    *_TOTAL : full line/frame lengths
//    *SYNC_START/END : inclusive sync pulse windows on hcount/vcount
//    HCW/VCW : counter widths
package vga_timing_pkg;
   localparam int H_ACTIVE    = 1024;
   localparam int H_FP        = 24;
   localparam int H_SYNC      = 136;
   localparam int H_BP        = 160;
   localparam int H_TOTAL     = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_ACTIVE    = 768;
   localparam int V_FP        = 3;
   localparam int V_SYNC      = 6;
   localparam int V_BP        = 29;
   localparam int V_TOTAL     = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HSYNC_START = H_ACTIVE + H_FP;
   localparam int HSYNC_END   = HSYNC_START + H_SYNC - 1;
   localparam int VSYNC_START = V_ACTIVE + V_FP;
   localparam int VSYNC_END   = VSYNC_START + V_SYNC - 1;
   localparam int HCW         = 11;
   localparam int VCW         = 10;
endpackage

// File: rtl/vga_timing_gen_wrap_counter.sv
// wrap_counter: counter that wraps from TC to 0
//    clk, reset : clock, async active-high reset
//    inc        : advance enable
//    count      : current value 0..TC
//    wrap       : high when count is at TC and inc is high (wraps on this edge)
module wrap_counter #(
   parameter int W  = 11,
   parameter int TC = 1343
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   output logic [W-1:0] count,
   output logic         wrap
);
   assign wrap = inc && count == W'(TC);
   always_ff @(posedge clk or posedge reset)
      if (reset) count <= '0;
      else if (inc) count <= wrap ? '0 : count + 1'b1;
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster counters, active-low syncs, blank and line/frame markers
//    clk, reset  : pixel clock, async active-high reset
//    ce          : pixel enable
//    hcount      : pixel column 0..H_TOTAL-1
//    vcount      : line 0..V_TOTAL-1
//    hsync/vsync : active-low sync pulses
//    blank       : high outside the active region
//    line_start  : one-cycle pulse when hcount becomes 0
//    frame_start : one-cycle pulse when (hcount,vcount) becomes (0,0)
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int H_ACTIVE = vga_timing_pkg::H_ACTIVE,
   parameter int H_FP     = vga_timing_pkg::H_FP,
   parameter int H_SYNC   = vga_timing_pkg::H_SYNC,
   parameter int H_BP     = vga_timing_pkg::H_BP,
   parameter int V_ACTIVE = vga_timing_pkg::V_ACTIVE,
   parameter int V_FP     = vga_timing_pkg::V_FP,
   parameter int V_SYNC   = vga_timing_pkg::V_SYNC,
   parameter int V_BP     = vga_timing_pkg::V_BP,
   parameter int HCW      = vga_timing_pkg::HCW,
   parameter int VCW      = vga_timing_pkg::VCW
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           ce,
   output logic [HCW-1:0] hcount,
   output logic [VCW-1:0] vcount,
   output logic           hsync,
   output logic           vsync,
   output logic           blank,
   output logic           line_start,
   output logic           frame_start
);
   localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam logic [HCW-1:0] HA  = HCW'(H_ACTIVE);
   localparam logic [HCW-1:0] HSS = HCW'(H_ACTIVE + H_FP);
   localparam logic [HCW-1:0] HSE = HCW'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [VCW-1:0] VA  = VCW'(V_ACTIVE);
   localparam logic [VCW-1:0] VSS = VCW'(V_ACTIVE + V_FP);
   localparam logic [VCW-1:0] VSE = VCW'(V_ACTIVE + V_FP + V_SYNC - 1);
   logic           hw, vw;
   logic [HCW-1:0] hn;
   logic [VCW-1:0] vn;
   wrap_counter #(.W(HCW), .TC(HT - 1)) u_h (
      .clk(clk), .reset(reset), .inc(ce), .count(hcount), .wrap(hw)
   );
   wrap_counter #(.W(VCW), .TC(VT - 1)) u_v (
      .clk(clk), .reset(reset), .inc(hw & ce), .count(vcount), .wrap(vw)
   );
   // next counter values, so the flags register in step with the counters
   always_comb begin
      hn = hw ? '0 : hcount + HCW'(ce);
      vn = vw ? '0 : vcount + VCW'(hw);
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         hsync       <= 1'b1;
         vsync       <= 1'b1;
         blank       <= 1'b0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         hsync       <= ~(hn >= HSS && hn <= HSE);
         vsync       <= ~(vn >= VSS && vn <= VSE);
         blank       <= hn >= HA || vn >= VA;
         line_start  <= hw;
         frame_start <= vw;
      end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench for a full-size and a shrunken raster
module tb_vga_timing_gen;
   typedef struct packed {
      logic [15:0] h;
      logic [15:0] v;
      logic        hs, vs, bl, ls, fs;
   } obs_t;
   typedef struct {
      obs_t a, b;
      logic c, r;
   } ent_t;

   localparam obs_t RST = {16'd0, 16'd0, 5'b11000};

   logic clk = 1'b0;
   logic reset, ce;
   logic [10:0] hcount_a;
   logic [9:0]  vcount_a;
   logic        hsync_a, vsync_a, blank_a, line_start_a, frame_start_a;
   logic [4:0]  hcount_b;
   logic [3:0]  vcount_b;
   logic        hsync_b, vsync_b, blank_b, line_start_b, frame_start_b;
   obs_t oa, ob, ma, mb;
   ent_t q[$];
   int tests = 0, fails = 0;
   int la_n = 0, fb_n = 0;
   bit la_seen = 0, fb_seen = 0;

   always #5 clk = ~clk;

   vga_timing_gen u_a (
      .clk(clk), .reset(reset), .ce(ce),
      .hcount(hcount_a), .vcount(vcount_a), .hsync(hsync_a), .vsync(vsync_a),
      .blank(blank_a), .line_start(line_start_a), .frame_start(frame_start_a)
   );

   // 16x13 raster: hsync 10..12, vsync 8..9, 208 clocks per frame
   vga_timing_gen #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3),
      .HCW(5), .VCW(4)
   ) u_b (
      .clk(clk), .reset(reset), .ce(ce),
      .hcount(hcount_b), .vcount(vcount_b), .hsync(hsync_b), .vsync(vsync_b),
      .blank(blank_b), .line_start(line_start_b), .frame_start(frame_start_b)
   );

   assign oa = {5'b0, hcount_a, 6'b0, vcount_a, hsync_a, vsync_a, blank_a, line_start_a, frame_start_a};
   assign ob = {11'b0, hcount_b, 12'b0, vcount_b, hsync_b, vsync_b, blank_b, line_start_b, frame_start_b};

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic obs_t nxt(input obs_t s, input logic c, input logic r,
                                input int ht, input int vt, input int ha, input int va,
                                input int hss, input int hse, input int vss, input int vse);
      obs_t n;
      n = s;
      if (r) n = RST;
      else if (c) begin
         n.ls = s.h == 16'(ht - 1);
         n.fs = n.ls && s.v == 16'(vt - 1);
         n.h  = n.ls ? 16'd0 : s.h + 16'd1;
         n.v  = n.ls ? (n.fs ? 16'd0 : s.v + 16'd1) : s.v;
         n.hs = !(n.h >= 16'(hss) && n.h <= 16'(hse));
         n.vs = !(n.v >= 16'(vss) && n.v <= 16'(vse));
         n.bl = n.h >= 16'(ha) || n.v >= 16'(va);
      end else begin
         n.ls = 1'b0;
         n.fs = 1'b0;
      end
      return n;
   endfunction

   task automatic step(input logic c, input logic r);
      ent_t e;
      @(negedge clk);
      ce = c;
      reset = r;
      ma = nxt(ma, c, r, 1344, 806, 1024, 768, 1048, 1183, 771, 776);
      mb = nxt(mb, c, r, 16, 13, 8, 6, 10, 12, 8, 9);
      e.a = ma;
      e.b = mb;
      e.c = c;
      e.r = r;
      q.push_back(e);
   endtask

   always @(posedge clk) begin
      ent_t e;
      #1;
      if (q.size() != 0) begin
         e = q.pop_front();
         check("sb_full", oa, e.a);
         check("sb_small", ob, e.b);
         if (e.r) begin
            la_n = 0; fb_n = 0; la_seen = 0; fb_seen = 0;
         end else if (e.c) begin
            la_n++;
            fb_n++;
            if (line_start_a) begin
               if (la_seen) check("line_period", la_n, 1344);
               la_seen = 1; la_n = 0;
            end
            if (frame_start_b) begin
               if (fb_seen) check("frame_period", fb_n, 208);
               fb_seen = 1; fb_n = 0;
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      ma = RST;
      mb = RST;
      reset = 1'b1;
      ce = 1'b1;
      repeat (5) step(1, 1);
      @(posedge clk); #2;
      check("rst_state", oa, RST);
      step(1, 0);
      @(posedge clk); #2;
      check("first_h", hcount_a, 1);
      check("first_flags", {hsync_a, vsync_a, blank_a, line_start_a, frame_start_a}, 5'b11000);
      while (ma.h != 16'd1048) step(1, 0);
      @(posedge clk); #2;
      check("hsync_fall", {hcount_a, hsync_a}, {11'd1048, 1'b0});
      while (ma.h != 16'd1184) step(1, 0);
      @(posedge clk); #2;
      check("hsync_rise", {hsync_a, blank_a}, 2'b11);
      while (ma.h != 16'd500) step(1, 0);
      step(0, 0);
      @(posedge clk); #2;
      check("ce_hold", {hcount_a, line_start_a, frame_start_a}, {11'd500, 2'b00});
      step(0, 0);
      step(1, 0);
      @(posedge clk); #2;
      check("ce_resume", hcount_a, 501);
      while (!(ma.h == 16'd1343 && ma.v == 16'd5)) step(1, 0);
      step(1, 0);
      @(posedge clk); #2;
      check("line_wrap", {hcount_a, vcount_a, line_start_a, frame_start_a, blank_a},
            {11'd0, 10'd6, 3'b100});
      while (ma.h != 16'd700) step(1, 0);
      @(posedge clk); #2;
      reset = 1'b1;
      #1;
      check("async_rst_full", oa, RST);
      check("async_rst_small", ob, RST);
      repeat (5) step(1, 1);
      step(1, 0);
      @(posedge clk); #2;
      check("rst2_h", {hcount_a, vcount_a, line_start_a}, {11'd1, 10'd0, 1'b0});
      repeat (300) step(1, 0);
      @(posedge clk); #2;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
